mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single unified instruction/data memory between the multicycle CPU and a DMA/program-loader port.
- Serialises one transaction at a time: request/ack handshake, memory strobes and read-data return routed to the winning requester.
- Fixed CPU priority, with a starvation bound so DMA always makes progress.
- Sits between the CPU memory port (driven by the I_or_D-muxed address) and the memory macro.

Parameters:
ADDR_WIDTH, 32, address width of both requesters and memory
DATA_WIDTH, 32, data width
MEM_LATENCY, 1, cycles from the issue edge to valid Mem_RData (>=1)
MAX_BURST, 4, consecutive CPU grants allowed while DMA_Req is pending (>=1)

Ports:
clk  in  1  clock, single domain
reset  in  1  synchronous, active-high
CPU_Req  in  1  CPU transaction request; level
CPU_Write  in  1  1=write, 0=read
CPU_Addr  in  ADDR_WIDTH  CPU address
CPU_WData  in  DATA_WIDTH  CPU write data
CPU_RData  out  DATA_WIDTH  CPU read data; valid with CPU_Ack, held until next CPU read Ack
CPU_Ack  out  1  one-cycle completion pulse
DMA_Req, DMA_Write, DMA_Addr, DMA_WData, DMA_RData, DMA_Ack  same directions, widths and meanings as the CPU set, for the DMA port
Mem_En  out  1  memory access strobe, one cycle per transaction
Mem_Write  out  1  write strobe, only together with Mem_En
Mem_Addr  out  ADDR_WIDTH  registered address
Mem_WData  out  DATA_WIDTH  registered write data
Mem_RData  in  DATA_WIDTH  memory read data
Grant  out  2  00 none, 01 CPU, 10 DMA

Behaviour:
Clocking and reset:
- Clock is clk; reset is synchronous and active-high. There is one clock domain.
- On reset, all outputs go to 0: Acks, RData registers, Mem_* outputs, Grant. The FSM goes to IDLE and the starvation counter clears.

State machine:
- IDLE: Req inputs are sampled only here. If either is high, select the winner and latch its Write/Addr/WData into holding registers; next state is ISSUE. Otherwise stay in IDLE.
- ISSUE: lasts 1 cycle. Mem_En=1, Mem_Write=latched Write, Mem_Addr/Mem_WData come from the latch. Next state is DONE for a write, or WAIT for a read.
- WAIT: lasts MEM_LATENCY cycles, tracked by a down-counter. On the last WAIT cycle, capture Mem_RData into the winner's RData register; next state is DONE.
- DONE: the winner's Ack=1 for exactly one cycle; next state is IDLE.

Timing and handshake:
- Grant is valid from ISSUE through DONE and is 00 in IDLE.
- Latency from the Req-sampling edge to Ack: write = 2 cycles; read = 2+MEM_LATENCY cycles.
- Throughput is one transaction per 3 (write) or 3+MEM_LATENCY (read) cycles.
- A requester holds Req/Write/Addr/WData stable until it sees Ack. Req still high in the cycle after Ack counts as a new request.
- Changes on Req/Addr after latching are ignored.
- The loser's request stays pending and is re-arbitrated in the next IDLE. It is never dropped.
- The non-winning port's RData is unchanged and its Ack stays 0.

Arbitration (default):
- CPU wins over DMA unless the starvation counter equals MAX_BURST and DMA_Req=1; in that case DMA wins and the counter clears.
- The counter increments on each CPU grant made while DMA_Req=1.
- The counter clears on any DMA grant, and on any grant made while DMA_Req=0.
- The counter saturates at MAX_BURST.

Boundary cases:
- Reset during ISSUE/WAIT/DONE aborts the transaction: no Ack is emitted and Mem_En is 0 in the following cycle.
- Simultaneous first requests after reset: CPU wins.

Optional Feature:
MEM_ARB_ROUND_ROBIN_EN:
- Defined: the starvation counter is removed. A last-grant flag (reset value: DMA) makes the other port win when both request, giving strict alternation under contention. A single requester is always granted.
- Undefined: fixed CPU priority with the MAX_BURST starvation bound, as above.

Decomposition:
- Package mem_arb_pkg: FSM state enum (IDLE, ISSUE, WAIT, DONE) and the Grant encoding constants (GNT_NONE, GNT_CPU, GNT_DMA).
- One sub-module, mem_arb_select: combinational winner selection from CPU_Req, DMA_Req, the starvation count (or last-grant flag) and MAX_BURST. It outputs the Grant encoding.
- The FSM, latency counter, holding registers and RData registers stay in mem_arbiter.

Test Plan:
1. Reset, then CPU read Addr=0x10, MEM_LATENCY=1, memory returns 0xDEADBEEF -> Mem_En one cycle with Mem_Addr=0x10 and Mem_Write=0; CPU_Ack 3 cycles after Req sampled; CPU_RData=0xDEADBEEF; DMA_Ack=0; Grant=01 during ISSUE..DONE.
2. DMA write Addr=0x20, WData=0x1234 -> Mem_En=Mem_Write=1 for one cycle with 0x20/0x1234; DMA_Ack 2 cycles after sampling; CPU_RData unchanged.
3. Both Reqs held continuously, MAX_BURST=4, macro undefined -> grant sequence CPU,CPU,CPU,CPU,DMA,CPU,CPU,CPU,CPU,DMA; no lost requests.
4. MEM_LATENCY=3, CPU read returning 0x55AA55AA -> Ack exactly 5 cycles after sampling; a Mem_RData glitch before the capture cycle is not visible on CPU_RData.
5. Reset asserted in the WAIT cycle of a DMA read -> next cycle Mem_En=0, no DMA_Ack, Grant=00. After release with DMA_Req still high, the read is re-issued and acked.
6. MEM_ARB_ROUND_ROBIN_EN defined, both Reqs continuous from reset -> grants CPU,DMA,CPU,DMA…; with only DMA_Req high, DMA is granted back-to-back.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the CPU/DMA memory arbiter: FSM state encoding and the
// Grant output encoding.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_CPU  = 2'b01;
  localparam logic [1:0] GNT_DMA  = 2'b10;

endpackage

// File: rtl/mem_arb_select.sv
// Winner selection between the CPU and DMA ports.
// Default build: fixed CPU priority, DMA forced through once the starvation
// count reaches MAX_BURST. With MEM_ARB_ROUND_ROBIN_EN defined the count is
// replaced by a last-grant flag and contention alternates strictly.
import mem_arb_pkg::*;

module mem_arb_select #(
`ifdef MEM_ARB_ROUND_ROBIN_EN
  parameter int UNUSED_W  = 1
`else
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 3
`endif
) (
  input  logic             cpu_req_i,
  input  logic             dma_req_i,
`ifdef MEM_ARB_ROUND_ROBIN_EN
  input  logic             last_dma_i,
`else
  input  logic [CNT_W-1:0] starv_cnt_i,
`endif
  output logic [1:0]       gnt_o
);

  // Pick the winner for the current IDLE cycle; GNT_NONE when nobody asks.
  always_comb begin
    gnt_o = GNT_NONE;
    if (cpu_req_i && dma_req_i) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      gnt_o = last_dma_i ? GNT_CPU : GNT_DMA;
`else
      gnt_o = (starv_cnt_i == CNT_W'(MAX_BURST)) ? GNT_DMA : GNT_CPU;
`endif
    end else if (cpu_req_i) begin
      gnt_o = GNT_CPU;
    end else if (dma_req_i) begin
      gnt_o = GNT_DMA;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one memory macro between the CPU and a DMA/loader port.
// One transaction at a time: IDLE -> ISSUE -> (WAIT x MEM_LATENCY) -> DONE.
// Optional macro MEM_ARB_ROUND_ROBIN_EN swaps the starvation-bounded CPU
// priority for strict alternation under contention.
//
//   state | meaning
//   IDLE  | sample requests, latch winner's command
//   ISSUE | drive Mem_En (and Mem_Write) for one cycle
//   WAIT  | count down memory latency, capture read data on last cycle
//   DONE  | one-cycle Ack to the winner
import mem_arb_pkg::*;

module mem_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 1,
  parameter int MAX_BURST   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  CPU_Req,
  input  logic                  CPU_Write,
  input  logic [ADDR_WIDTH-1:0] CPU_Addr,
  input  logic [DATA_WIDTH-1:0] CPU_WData,
  output logic [DATA_WIDTH-1:0] CPU_RData,
  output logic                  CPU_Ack,
  input  logic                  DMA_Req,
  input  logic                  DMA_Write,
  input  logic [ADDR_WIDTH-1:0] DMA_Addr,
  input  logic [DATA_WIDTH-1:0] DMA_WData,
  output logic [DATA_WIDTH-1:0] DMA_RData,
  output logic                  DMA_Ack,
  output logic                  Mem_En,
  output logic                  Mem_Write,
  output logic [ADDR_WIDTH-1:0] Mem_Addr,
  output logic [DATA_WIDTH-1:0] Mem_WData,
  input  logic [DATA_WIDTH-1:0] Mem_RData,
  output logic [1:0]            Grant
);

  localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_e            state_q, state_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [1:0]            gnt_q, gnt_d;
  logic [LAT_W-1:0]      lat_q, lat_d;
  logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_WIDTH-1:0] dma_rdata_q, dma_rdata_d;
  logic [1:0]            sel_gnt;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic                  last_dma_q, last_dma_d;
`else
  logic [CNT_W-1:0]      starv_q, starv_d;
`endif

`ifdef MEM_ARB_ROUND_ROBIN_EN
  mem_arb_select u_select (
    .cpu_req_i  (CPU_Req),
    .dma_req_i  (DMA_Req),
    .last_dma_i (last_dma_q),
    .gnt_o      (sel_gnt)
  );
`else
  mem_arb_select #(
    .MAX_BURST (MAX_BURST),
    .CNT_W     (CNT_W)
  ) u_select (
    .cpu_req_i   (CPU_Req),
    .dma_req_i   (DMA_Req),
    .starv_cnt_i (starv_q),
    .gnt_o       (sel_gnt)
  );
`endif

  // State and datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      gnt_q       <= GNT_NONE;
      lat_q       <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_dma_q  <= 1'b1;
`else
      starv_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      gnt_q       <= gnt_d;
      lat_q       <= lat_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_dma_q  <= last_dma_d;
`else
      starv_q     <= starv_d;
`endif
    end
  end

  // Next-state, command latching, latency countdown and read-data capture.
  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    gnt_d       = gnt_q;
    lat_d       = lat_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_dma_d  = last_dma_q;
`else
    starv_d     = starv_q;
`endif
    case (state_q)
      IDLE: begin
        if (sel_gnt != GNT_NONE) begin
          state_d = ISSUE;
          gnt_d   = sel_gnt;
          if (sel_gnt == GNT_CPU) begin
            wr_d    = CPU_Write;
            addr_d  = CPU_Addr;
            wdata_d = CPU_WData;
          end else begin
            wr_d    = DMA_Write;
            addr_d  = DMA_Addr;
            wdata_d = DMA_WData;
          end
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_dma_d = (sel_gnt == GNT_DMA);
`else
          // Only CPU grants that bypass a waiting DMA count toward starvation.
          if (sel_gnt == GNT_CPU && DMA_Req) begin
            if (starv_q != CNT_W'(MAX_BURST)) starv_d = starv_q + CNT_W'(1);
          end else begin
            starv_d = '0;
          end
`endif
        end
      end
      ISSUE: begin
        state_d = wr_q ? DONE : WAIT;
        lat_d   = LAT_W'(MEM_LATENCY - 1);
      end
      WAIT: begin
        if (lat_q == '0) begin
          state_d = DONE;
          if (gnt_q == GNT_CPU) cpu_rdata_d = Mem_RData;
          else                  dma_rdata_d = Mem_RData;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the current state and holding registers.
  always_comb begin
    Mem_En    = (state_q == ISSUE);
    Mem_Write = (state_q == ISSUE) && wr_q;
    Mem_Addr  = addr_q;
    Mem_WData = wdata_q;
    CPU_Ack   = (state_q == DONE) && (gnt_q == GNT_CPU);
    DMA_Ack   = (state_q == DONE) && (gnt_q == GNT_DMA);
    CPU_RData = cpu_rdata_q;
    DMA_RData = dma_rdata_q;
    Grant     = (state_q == IDLE) ? GNT_NONE : gnt_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a MEM_LATENCY=1 instance for the main
// sequence and a MEM_LATENCY=3 instance for the long-latency read.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        cpu_req, cpu_write, cpu_ack;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        dma_req, dma_write, dma_ack;
  logic [31:0] dma_addr, dma_wdata, dma_rdata;
  logic        mem_en, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  grant;

  logic        c3_req, c3_write, c3_ack;
  logic [31:0] c3_addr, c3_wdata, c3_rdata;
  logic        d3_req, d3_write, d3_ack;
  logic [31:0] d3_addr, d3_wdata, d3_rdata;
  logic        m3_en, m3_write;
  logic [31:0] m3_addr, m3_wdata, m3_rdata;
  logic [1:0]  grant3;

  int vectors = 0;
  int miscompares = 0;

  mem_arbiter #(.MEM_LATENCY(1), .MAX_BURST(4)) u_dut (
    .clk(clk), .reset(reset),
    .CPU_Req(cpu_req), .CPU_Write(cpu_write), .CPU_Addr(cpu_addr),
    .CPU_WData(cpu_wdata), .CPU_RData(cpu_rdata), .CPU_Ack(cpu_ack),
    .DMA_Req(dma_req), .DMA_Write(dma_write), .DMA_Addr(dma_addr),
    .DMA_WData(dma_wdata), .DMA_RData(dma_rdata), .DMA_Ack(dma_ack),
    .Mem_En(mem_en), .Mem_Write(mem_write), .Mem_Addr(mem_addr),
    .Mem_WData(mem_wdata), .Mem_RData(mem_rdata), .Grant(grant)
  );

  mem_arbiter #(.MEM_LATENCY(3), .MAX_BURST(4)) u_dut3 (
    .clk(clk), .reset(reset),
    .CPU_Req(c3_req), .CPU_Write(c3_write), .CPU_Addr(c3_addr),
    .CPU_WData(c3_wdata), .CPU_RData(c3_rdata), .CPU_Ack(c3_ack),
    .DMA_Req(d3_req), .DMA_Write(d3_write), .DMA_Addr(d3_addr),
    .DMA_WData(d3_wdata), .DMA_RData(d3_rdata), .DMA_Ack(d3_ack),
    .Mem_En(m3_en), .Mem_Write(m3_write), .Mem_Addr(m3_addr),
    .Mem_WData(m3_wdata), .Mem_RData(m3_rdata), .Grant(grant3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [1:0] exp3 [10];
  int         cpu_stop;
  int         n;

  initial begin
    reset = 1'b1;
    cpu_req = 0; cpu_write = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_write = 0; dma_addr = 0; dma_wdata = 0;
    mem_rdata = 0;
    c3_req = 0; c3_write = 0; c3_addr = 0; c3_wdata = 0;
    d3_req = 0; d3_write = 0; d3_addr = 0; d3_wdata = 0;
    m3_rdata = 0;

    // Reset state
    step; step;
    check("rst_grant", 32'(grant), 32'(2'b00));
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_cpu_ack", 32'(cpu_ack), 32'd0);
    check("rst_cpu_rdata", cpu_rdata, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    reset = 1'b0;
    step;

    // 1: CPU read, latency 1
    cpu_req = 1; cpu_write = 0; cpu_addr = 32'h10;
    step;
    check("t1_issue_en", 32'(mem_en), 32'd1);
    check("t1_issue_wr", 32'(mem_write), 32'd0);
    check("t1_issue_addr", mem_addr, 32'h10);
    check("t1_issue_grant", 32'(grant), 32'(2'b01));
    check("t1_issue_ack", 32'(cpu_ack), 32'd0);
    mem_rdata = 32'hDEADBEEF;
    step;
    check("t1_wait_en", 32'(mem_en), 32'd0);
    check("t1_wait_ack", 32'(cpu_ack), 32'd0);
    check("t1_wait_grant", 32'(grant), 32'(2'b01));
    step;
    check("t1_cpu_ack", 32'(cpu_ack), 32'd1);
    check("t1_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
    check("t1_dma_ack", 32'(dma_ack), 32'd0);
    check("t1_done_grant", 32'(grant), 32'(2'b01));
    cpu_req = 0;
    step;
    check("t1_ack_pulse", 32'(cpu_ack), 32'd0);
    step;
    check("t1_idle_grant", 32'(grant), 32'(2'b00));
    check("t1_idle_en", 32'(mem_en), 32'd0);

    // 2: DMA write
    dma_req = 1; dma_write = 1; dma_addr = 32'h20; dma_wdata = 32'h1234;
    step;
    check("t2_issue_en", 32'(mem_en), 32'd1);
    check("t2_issue_wr", 32'(mem_write), 32'd1);
    check("t2_issue_addr", mem_addr, 32'h20);
    check("t2_issue_wdata", mem_wdata, 32'h1234);
    check("t2_issue_grant", 32'(grant), 32'(2'b10));
    step;
    check("t2_dma_ack", 32'(dma_ack), 32'd1);
    check("t2_cpu_ack", 32'(cpu_ack), 32'd0);
    check("t2_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
    check("t2_done_en", 32'(mem_en), 32'd0);
    dma_req = 0; dma_write = 0;
    step; step;

    // 3 / 6: contention from reset
    reset = 1'b1;
    step;
    reset = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp3 = '{GNT_CPU, GNT_DMA, GNT_CPU, GNT_DMA, GNT_CPU, GNT_DMA,
             GNT_DMA, GNT_DMA, GNT_DMA, GNT_DMA};
    cpu_stop = 5;
`else
    exp3 = '{GNT_CPU, GNT_CPU, GNT_CPU, GNT_CPU, GNT_DMA,
             GNT_CPU, GNT_CPU, GNT_CPU, GNT_CPU, GNT_DMA};
    cpu_stop = 9;
`endif
    cpu_req = 1; cpu_write = 1; cpu_addr = 32'h100; cpu_wdata = 32'hC0;
    dma_req = 1; dma_write = 1; dma_addr = 32'h200; dma_wdata = 32'hD0;
    for (int t = 0; t < 10; t++) begin
      n = 0;
      while (mem_en !== 1'b1 && n < 16) begin
        step;
        n++;
      end
      check($sformatf("t3_issue_%0d", t), 32'(mem_en), 32'd1);
      check($sformatf("t3_grant_%0d", t), 32'(grant), 32'(exp3[t]));
      step;
      check($sformatf("t3_cpu_ack_%0d", t), 32'(cpu_ack), 32'(exp3[t] == GNT_CPU));
      check($sformatf("t3_dma_ack_%0d", t), 32'(dma_ack), 32'(exp3[t] == GNT_DMA));
      if (t == cpu_stop) cpu_req = 0;
      if (t == 9) dma_req = 0;
    end
    cpu_write = 0; dma_write = 0;
    step; step;
    check("t3_idle_grant", 32'(grant), 32'(2'b00));

    // 4: latency-3 CPU read with a glitch before the capture cycle
    c3_req = 1; c3_write = 0; c3_addr = 32'h40;
    step;
    check("t4_issue_en", 32'(m3_en), 32'd1);
    check("t4_issue_wr", 32'(m3_write), 32'd0);
    check("t4_issue_addr", m3_addr, 32'h40);
    check("t4_issue_wdata", m3_wdata, 32'd0);
    check("t4_issue_grant", 32'(grant3), 32'(2'b01));
    m3_rdata = 32'hBAD0BAD0;
    for (int k = 2; k <= 4; k++) begin
      step;
      check($sformatf("t4_wait_ack_%0d", k), 32'(c3_ack), 32'd0);
      check($sformatf("t4_wait_rdata_%0d", k), c3_rdata, 32'd0);
      if (k == 3) m3_rdata = 32'h0F0F0F0F;
      if (k == 4) m3_rdata = 32'h55AA55AA;
    end
    step;
    check("t4_cpu_ack", 32'(c3_ack), 32'd1);
    check("t4_cpu_rdata", c3_rdata, 32'h55AA55AA);
    check("t4_dma_ack", 32'(d3_ack), 32'd0);
    check("t4_dma_rdata", d3_rdata, 32'd0);
    c3_req = 0;
    m3_rdata = 32'h12121212;
    step;
    check("t4_rdata_hold", c3_rdata, 32'h55AA55AA);
    step;

    // 5: reset during WAIT of a DMA read, then re-issue
    dma_req = 1; dma_write = 0; dma_addr = 32'h30;
    step;
    check("t5_issue_addr", mem_addr, 32'h30);
    check("t5_issue_grant", 32'(grant), 32'(2'b10));
    step;
    reset = 1'b1;
    step;
    check("t5_rst_en", 32'(mem_en), 32'd0);
    check("t5_rst_ack", 32'(dma_ack), 32'd0);
    check("t5_rst_grant", 32'(grant), 32'(2'b00));
    check("t5_rst_addr", mem_addr, 32'd0);
    reset = 1'b0;
    mem_rdata = 32'hCAFEF00D;
    step;
    check("t5_reissue_en", 32'(mem_en), 32'd1);
    check("t5_reissue_addr", mem_addr, 32'h30);
    check("t5_reissue_ack", 32'(dma_ack), 32'd0);
    step;
    check("t5_wait_ack", 32'(dma_ack), 32'd0);
    step;
    check("t5_dma_ack", 32'(dma_ack), 32'd1);
    check("t5_dma_rdata", dma_rdata, 32'hCAFEF00D);
    check("t5_cpu_ack", 32'(cpu_ack), 32'd0);
    check("t5_cpu_rdata", cpu_rdata, 32'd0);
    dma_req = 0;
    step; step;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
